// File: rtl/dma_axi_rd_resp.sv
// AXI4 read-response engine for the DMA: queues AR requests, walks each burst
// against a 1-cycle-latency SRAM and returns R beats through a 2-entry skid.
module dma_axi_rd_resp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned TXN_BUFF   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [31:0]                  araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam int unsigned BYTE_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned QW       = $clog2(TXN_BUFF);
  localparam int unsigned CW       = QW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_t;

  // AR queue
  ar_t           q_mem [TXN_BUFF];
  logic [QW-1:0] q_wr, q_rd;
  logic [CW-1:0] q_cnt, q_cnt_nxt;
  logic          q_empty, push, pop;
  ar_t           head, ar_in;

  // burst engine
  logic [0:0]    state_q, state_d;
  ar_t           cur_q, cur_d;
  logic [7:0]    beat_q, beat_d;
  ar_t           desc;
  logic [7:0]    beat;
  logic          have, issue, credit_ok, last_beat, beat_err, len_ok;
  logic [31:0]   nbytes, aligned, step, wrap_bytes, wrap_base, wrap_off;
  logic [31:0]   beat_addr, word;

  // in-flight beat and skid buffer
  logic                if_valid_q, if_err_q, if_last_q;
  logic [ID_WIDTH-1:0] if_id_q;
  r_t                  beat_in, buf0_q, buf1_q, r_out;
  logic [1:0]          buf_cnt, occ;
  logic                fire;

  assign ar_in   = {arid, araddr, arlen, arsize, arburst};
  assign push    = arvalid && arready;
  assign q_empty = (q_cnt == '0);
  assign head    = q_mem[q_rd];
  assign q_cnt_nxt = q_cnt + CW'(push) - CW'(pop);

  // Queue storage; entries are only read once counted, so no reset needed
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= ar_in;
  end

  // Queue pointers, occupancy and registered ready (no push/pop bypass when full)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_cnt   <= '0;
      arready <= 1'b0;
    end else begin
      if (push) q_wr <= q_wr + QW'(1);
      if (pop)  q_rd <= q_rd + QW'(1);
      q_cnt   <= q_cnt_nxt;
      arready <= (q_cnt_nxt != CW'(TXN_BUFF));
    end
  end

  // Select the descriptor for this cycle's beat: queue head from IDLE, else current burst
  always_comb begin
    desc = cur_q;
    beat = beat_q;
    have = 1'b1;
    if (state_q == S_IDLE) begin
      desc = head;
      beat = 8'd0;
      have = !q_empty;
    end
  end

  // Beat address, word index and error classification
  always_comb begin
    nbytes     = 32'd1 << desc.size;
    aligned    = desc.addr & ~(nbytes - 32'd1);
    step       = 32'(beat) << desc.size;
    wrap_bytes = (32'(desc.len) + 32'd1) << desc.size;
    wrap_base  = desc.addr & ~(wrap_bytes - 32'd1);
    wrap_off   = (aligned - wrap_base + step) & (wrap_bytes - 32'd1);
    case (desc.burst)
      2'b00:   beat_addr = desc.addr;
      2'b10:   beat_addr = wrap_base + wrap_off;
      default: beat_addr = aligned + step;
    endcase
    word      = beat_addr >> BYTE_LSB;
    len_ok    = (desc.len == 8'd1) || (desc.len == 8'd3) ||
                (desc.len == 8'd7) || (desc.len == 8'd15);
    beat_err  = (desc.size > 3'(BYTE_LSB)) || (desc.burst == 2'b11) ||
                ((desc.burst == 2'b10) && !len_ok) || (word >= 32'(MEM_WORDS));
    last_beat = (beat == desc.len);
  end

  // A beat may issue only while buffered plus in-flight beats stay below two
  assign occ       = buf_cnt + {1'b0, if_valid_q};
  assign credit_ok = (occ < 2'd2);
  assign issue     = have && credit_ok;
  assign mem_rd_en = issue && !beat_err;
  assign mem_addr  = mem_rd_en ? word[AW-1:0] : '0;

  // Burst FSM next state; the next head is popped on the last beat so bursts abut
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          pop   = 1'b1;
          cur_d = head;
          if (issue && last_beat) begin
            state_d = S_IDLE;
            beat_d  = 8'd0;
          end else begin
            state_d = S_BURST;
            beat_d  = issue ? 8'd1 : 8'd0;
          end
        end
      end
      S_BURST: begin
        if (issue) begin
          if (last_beat) begin
            beat_d = 8'd0;
            if (!q_empty) begin
              pop   = 1'b1;
              cur_d = head;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
    end
  end

  // Side information for the beat whose SRAM data arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      if_last_q  <= 1'b0;
      if_id_q    <= '0;
    end else begin
      if_valid_q <= issue;
      if_err_q   <= beat_err;
      if_last_q  <= last_beat;
      if_id_q    <= desc.id;
    end
  end

  // In-flight beat as seen this cycle, with SRAM data merged in
  always_comb begin
    beat_in.id   = if_id_q;
    beat_in.data = if_err_q ? '0 : mem_rdata;
    beat_in.resp = if_err_q ? RESP_SLVERR : RESP_OKAY;
    beat_in.last = if_last_q;
  end

  // R output: oldest buffered beat first, else the in-flight beat passes straight through
  always_comb begin
    r_out = '0;
    if (buf_cnt != 2'd0) r_out = buf0_q;
    else if (if_valid_q) r_out = beat_in;
  end

  assign rvalid = (buf_cnt != 2'd0) || if_valid_q;
  assign fire   = rvalid && rready;
  assign rid    = r_out.id;
  assign rdata  = r_out.data;
  assign rresp  = r_out.resp;
  assign rlast  = r_out.last;

  // Skid buffer: keeps unaccepted beats in order so a stall loses nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      case (buf_cnt)
        2'd0: begin
          if (if_valid_q && !fire) begin
            buf0_q  <= beat_in;
            buf_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (fire) begin
            if (if_valid_q) buf0_q <= beat_in;
            else            buf_cnt <= 2'd0;
          end else if (if_valid_q) begin
            buf1_q  <= beat_in;
            buf_cnt <= 2'd2;
          end
        end
        default: begin
          if (fire) begin
            buf0_q  <= buf1_q;
            buf_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule
